sensor_fusion_scheduler: RTL

SENSOR_FUSION_SCHEDULER -- requirements
Module: sensor_fusion_scheduler

---
 rtl/sensor_fusion_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sensor_fusion_scheduler.sv
// rtl/sensor_fusion_scheduler.sv - collects sensor frames and launches the fusion core
// Define SCHED_PERF_COUNTERS_EN to build the latency and frame_count registers.
module sensor_fusion_scheduler #(
  parameter int unsigned COLLECT_TIMEOUT = 1000,
  parameter int unsigned DONE_TIMEOUT    = 4096,
  parameter int unsigned MIN_SENSORS     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sensor_valid,
  output logic [3:0]  sensor_ready,
  output logic        fusion_start,
  output logic [3:0]  fusion_mask,
  input  logic        fusion_done,
  input  logic        err_clear,
  output logic [3:0]  error_flags,
  output logic [31:0] latency,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, LAUNCH, WAIT_DONE} state_e;

  localparam logic [31:0] CT_LAST = 32'(COLLECT_TIMEOUT - 1);
  localparam logic [31:0] DT_LAST = 32'(DONE_TIMEOUT);
  localparam logic [2:0]  MIN_CNT = 3'(MIN_SENSORS);

  state_e      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  err_q, err_d, err_set;
  logic [3:0]  capture, mask_next;
  logic [2:0]  mask_cnt;

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    sensor_ready = 4'h0;
    if (rst_n && (state_q == IDLE || state_q == COLLECT)) sensor_ready = ~mask_q;
  end

  assign capture   = sensor_valid & sensor_ready;
  assign mask_next = mask_q | capture;
  assign mask_cnt  = 3'(mask_next[0]) + 3'(mask_next[1]) + 3'(mask_next[2]) + 3'(mask_next[3]);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    timer_d = timer_q;
    err_set = 4'h0;
    case (state_q)
      IDLE: begin
        if (|capture) begin
          mask_d  = capture;
          timer_d = 32'd0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // Captures on the expiry edge are already folded into mask_next.
        mask_d  = mask_next;
        timer_d = timer_q + 32'd1;
        if (mask_next == 4'hF) begin
          state_d = LAUNCH;
        end else if (timer_q >= CT_LAST) begin
          if (mask_cnt >= MIN_CNT) begin
            state_d    = LAUNCH;
            err_set[0] = 1'b1;
          end else begin
            state_d    = IDLE;
            mask_d     = 4'h0;
            timer_d    = 32'd0;
            err_set[1] = 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        timer_d = 32'd1;
      end
      WAIT_DONE: begin
        if (fusion_done) begin
          state_d = IDLE;
          mask_d  = 4'h0;
          timer_d = 32'd0;
        end else if (timer_q >= DT_LAST) begin
          state_d    = IDLE;
          mask_d     = 4'h0;
          timer_d    = 32'd0;
          err_set[2] = 1'b1;
        end else if (timer_q != 32'hFFFF_FFFF) begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fusion_done && state_q != WAIT_DONE) err_set[3] = 1'b1;
    err_d = (err_clear ? 4'h0 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 4'h0;
      timer_q <= 32'd0;
      err_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign fusion_start = (state_q == LAUNCH);
  assign fusion_mask  = (state_q == LAUNCH || state_q == WAIT_DONE) ? mask_q : 4'h0;
  assign error_flags  = err_q;

`ifdef SCHED_PERF_COUNTERS_EN
  logic [31:0] latency_q;
  logic [15:0] frame_count_q;

  // timer_q holds cycles since fusion_start while in WAIT_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latency_q     <= 32'd0;
      frame_count_q <= 16'd0;
    end else if (state_q == WAIT_DONE && fusion_done) begin
      latency_q     <= timer_q;
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign latency     = latency_q;
  assign frame_count = frame_count_q;
`else
  assign latency     = 32'd0;
  assign frame_count = 16'd0;
`endif

endmodule
